// File: rtl/rv32i_wb_stage_if.sv
// Bundle of the MEM/WB stage signals: upstream handoff, load response, regfile write,
// decode bypass, hazard status and retirement counter.
interface rv32i_wb_stage_if #(
    parameter int unsigned CNT_W = 64
);
    logic             ex_valid;
    logic             ex_ready;
    logic             ex_rd_we;
    logic [4:0]       ex_rd;
    logic [31:0]      ex_result;
    logic             ex_is_load;
    logic [2:0]       ex_funct3;
    logic             dmem_rvalid;
    logic [31:0]      dmem_rdata;
    logic             RegWE;
    logic [4:0]       RegWA;
    logic [31:0]      RegWD;
    logic [4:0]       Reg1RA;
    logic [31:0]      Reg1RD;
    logic [4:0]       Reg2RA;
    logic [31:0]      Reg2RD;
    logic [31:0]      fwd1_data;
    logic [31:0]      fwd2_data;
    logic             pend_valid;
    logic [4:0]       pend_rd;
    logic             retire;
    logic [CNT_W-1:0] instret;

    // Upstream pipeline / environment side.
    modport master (
        output ex_valid, ex_rd_we, ex_rd, ex_result, ex_is_load, ex_funct3,
        output dmem_rvalid, dmem_rdata,
        output Reg1RA, Reg1RD, Reg2RA, Reg2RD,
        input  ex_ready, RegWE, RegWA, RegWD, fwd1_data, fwd2_data,
        input  pend_valid, pend_rd, retire, instret
    );

    // The WB stage itself.
    modport slave (
        input  ex_valid, ex_rd_we, ex_rd, ex_result, ex_is_load, ex_funct3,
        input  dmem_rvalid, dmem_rdata,
        input  Reg1RA, Reg1RD, Reg2RA, Reg2RD,
        output ex_ready, RegWE, RegWA, RegWD, fwd1_data, fwd2_data,
        output pend_valid, pend_rd, retire, instret
    );
endinterface

// File: rtl/rv32i_wb_stage.sv
// MEM/WB stage: holds one retiring instruction, extends load data, drives the regfile
// write port and counts retirements. Define RV32I_WB_BYPASS_EN for write->read bypass.
module rv32i_wb_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 64
) (
    input logic              clk,
    input logic              rst_n,
    rv32i_wb_stage_if.slave  bus
);
    typedef enum logic [1:0] {StEmpty, StWaitLoad, StWrite} state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic              r_rd_we;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_data;
    logic              r_is_load;
    logic [2:0]        r_funct3;
    logic [1:0]        r_addr;
    logic [CNT_W-1:0]  r_instret;

    logic              w_ready;
    logic              w_accept;
    logic              w_write;
    logic              w_reg_we;
    logic [4:0]        w_reg_wa;
    logic [XLEN-1:0]   w_reg_wd;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [XLEN-1:0]   w_load_data;

    assign w_ready  = (r_state == StEmpty) || (r_state == StWrite);
    assign w_accept = bus.ex_valid && w_ready;
    assign w_write  = (r_state == StWrite);

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StEmpty: begin
                if (w_accept) w_state_d = bus.ex_is_load ? StWaitLoad : StWrite;
            end
            StWaitLoad: begin
                if (bus.dmem_rvalid) w_state_d = StWrite;
            end
            StWrite: begin
                if (w_accept) w_state_d = bus.ex_is_load ? StWaitLoad : StWrite;
                else          w_state_d = StEmpty;
            end
            default: w_state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= StEmpty;
        else        r_state <= w_state_d;
    end

    // Memory returns the aligned word; pick the lane from the latched byte address.
    always_comb begin
        w_byte      = bus.dmem_rdata[7:0];
        w_half      = r_addr[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
        w_load_data = '0;
        case (r_addr)
            2'd1:    w_byte = bus.dmem_rdata[15:8];
            2'd2:    w_byte = bus.dmem_rdata[23:16];
            2'd3:    w_byte = bus.dmem_rdata[31:24];
            default: w_byte = bus.dmem_rdata[7:0];
        endcase
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b010:  w_load_data = bus.dmem_rdata;
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_we   <= 1'b0;
            r_rd      <= '0;
            r_data    <= '0;
            r_is_load <= 1'b0;
            r_funct3  <= '0;
            r_addr    <= '0;
            r_instret <= '0;
        end else begin
            if (w_accept) begin
                r_rd_we   <= bus.ex_rd_we;
                r_rd      <= bus.ex_rd;
                r_data    <= bus.ex_result;
                r_is_load <= bus.ex_is_load;
                r_funct3  <= bus.ex_funct3;
                r_addr    <= bus.ex_result[1:0];
            end else if ((r_state == StWaitLoad) && bus.dmem_rvalid && r_is_load) begin
                r_data <= w_load_data;
            end
            // Counted on entry so the value seen during WRITE includes that instruction.
            if (w_state_d == StWrite) r_instret <= r_instret + CNT_W'(1);
        end
    end

    assign w_reg_we = w_write && r_rd_we && (r_rd != 5'd0);
    assign w_reg_wa = w_write ? r_rd : 5'd0;
    assign w_reg_wd = w_write ? r_data : '0;

    assign bus.ex_ready   = w_ready;
    assign bus.RegWE      = w_reg_we;
    assign bus.RegWA      = w_reg_wa;
    assign bus.RegWD      = w_reg_wd;
    assign bus.retire     = w_write;
    assign bus.instret    = r_instret;
    assign bus.pend_valid = (r_state == StWaitLoad) && r_is_load;
    assign bus.pend_rd    = ((r_state == StWaitLoad) && r_rd_we) ? r_rd : 5'd0;

`ifdef RV32I_WB_BYPASS_EN
    assign bus.fwd1_data = (w_reg_we && (w_reg_wa == bus.Reg1RA)) ? w_reg_wd : bus.Reg1RD;
    assign bus.fwd2_data = (w_reg_we && (w_reg_wa == bus.Reg2RA)) ? w_reg_wd : bus.Reg2RD;
`else
    logic w_unused_ra;
    assign w_unused_ra   = ^{bus.Reg1RA, bus.Reg2RA};
    assign bus.fwd1_data = bus.Reg1RD;
    assign bus.fwd2_data = bus.Reg2RD;
`endif

endmodule

// File: tb/tb_rv32i_wb_stage.sv
// Directed bench for rv32i_wb_stage: expected regfile writes are queued at issue time
// and popped when the stage retires.
module tb_rv32i_wb_stage;
    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [63:0] cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t sb[$];
    int   n_pass;
    int   n_fail;
    int   n_total;
    logic [63:0] exp_cnt;
    logic [31:0] exp_fwd1;

    rv32i_wb_stage_if #(.CNT_W(64)) bus ();

    rv32i_wb_stage #(
        .XLEN  (32),
        .CNT_W (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic we, input logic [4:0] wa, input logic [31:0] wd);
        exp_t e;
        exp_cnt = exp_cnt + 64'd1;
        e.we  = we;
        e.wa  = wa;
        e.wd  = wd;
        e.cnt = exp_cnt;
        sb.push_back(e);
    endtask

    // Waits (bounded) for a retire pulse, then compares it with the oldest expectation.
    task automatic expect_write(input string tag);
        exp_t e;
        int   k;
        k = 0;
        while (bus.retire !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_retire"}, 64'(bus.retire), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_we"},  64'(bus.RegWE), 64'(e.we));
            check({tag, "_wa"},  64'(bus.RegWA), 64'(e.wa));
            check({tag, "_wd"},  64'(bus.RegWD), 64'(e.wd));
            check({tag, "_cnt"}, bus.instret,    e.cnt);
        end else begin
            check({tag, "_sb"}, 64'(sb.size()), 64'd1);
        end
    endtask

    task automatic issue(input logic we, input logic [4:0] rd, input logic [31:0] res,
                         input logic ld, input logic [2:0] f3);
        @(negedge clk);
        bus.ex_valid   = 1'b1;
        bus.ex_rd_we   = we;
        bus.ex_rd      = rd;
        bus.ex_result  = res;
        bus.ex_is_load = ld;
        bus.ex_funct3  = f3;
        @(negedge clk);
        bus.ex_valid   = 1'b0;
        bus.ex_is_load = 1'b0;
    endtask

    task automatic load_test(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] rdata,
                             input logic [31:0] expd);
        issue(1'b1, rd, addr, 1'b1, f3);
        check({tag, "_ready0"}, 64'(bus.ex_ready),   64'd0);
        check({tag, "_pend"},   64'(bus.pend_valid), 64'd1);
        check({tag, "_pendrd"}, 64'(bus.pend_rd),    64'(rd));
        repeat (3) @(negedge clk);
        check({tag, "_hold"},   64'(bus.pend_valid), 64'd1);
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = rdata;
        push(1'b1, rd, expd);
        @(negedge clk);
        bus.dmem_rvalid = 1'b0;
        expect_write(tag);
        @(negedge clk);
        check({tag, "_pendclr"}, 64'(bus.pend_rd), 64'd0);
    endtask

    initial begin
        n_pass  = 0;
        n_fail  = 0;
        n_total = 0;
        exp_cnt = '0;
        rst_n           = 1'b0;
        bus.ex_valid    = 1'b0;
        bus.ex_rd_we    = 1'b0;
        bus.ex_rd       = '0;
        bus.ex_result   = '0;
        bus.ex_is_load  = 1'b0;
        bus.ex_funct3   = '0;
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata  = '0;
        bus.Reg1RA      = 5'd7;
        bus.Reg1RD      = 32'h0;
        bus.Reg2RA      = 5'd8;
        bus.Reg2RD      = 32'h55;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready",   64'(bus.ex_ready),   64'd1);
        check("rst_we",      64'(bus.RegWE),      64'd0);
        check("rst_retire",  64'(bus.retire),     64'd0);
        check("rst_pend",    64'(bus.pend_valid), 64'd0);
        check("rst_instret", bus.instret,         64'd0);

        // Single ALU op.
        push(1'b1, 5'd5, 32'h1234_5678);
        issue(1'b1, 5'd5, 32'h1234_5678, 1'b0, 3'b000);
        expect_write("alu5");
        @(negedge clk);
        check("alu5_pulse", 64'(bus.retire), 64'd0);
        check("alu5_wd0",   64'(bus.RegWD),  64'd0);

        // Three back-to-back ALU ops: one write per cycle, never stalled.
        for (int i = 0; i < 4; i++) begin
            if (i > 0) expect_write($sformatf("b2b%0d", i));
            if (i < 3) begin
                check($sformatf("b2b_ready%0d", i), 64'(bus.ex_ready), 64'd1);
                bus.ex_valid   = 1'b1;
                bus.ex_rd_we   = 1'b1;
                bus.ex_rd      = 5'(i + 1);
                bus.ex_result  = 32'hA000_0000 + 32'(i);
                bus.ex_is_load = 1'b0;
                push(1'b1, 5'(i + 1), 32'hA000_0000 + 32'(i));
            end else begin
                bus.ex_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b_idle", 64'(bus.retire), 64'd0);

        load_test("lb",  5'd9,  3'b000, 32'h0000_1003, 32'h80FF_FF7F, 32'hFFFF_FF80);
        load_test("lhu", 5'd10, 3'b101, 32'h0000_2002, 32'h8001_0000, 32'h0000_8001);
        load_test("lh",  5'd11, 3'b001, 32'h0000_3000, 32'h0000_9001, 32'hFFFF_9001);
        load_test("lbu", 5'd12, 3'b100, 32'h0000_4001, 32'h1234_F0CD, 32'h0000_00F0);
        load_test("lw",  5'd13, 3'b010, 32'h0000_5003, 32'hCAFE_BABE, 32'hCAFE_BABE);
        load_test("f011", 5'd14, 3'b011, 32'h0000_6000, 32'hFFFF_FFFF, 32'h0000_0000);

        // Store (rd_we=0) and write to x0 both retire without a regfile write.
        push(1'b0, 5'd4, 32'h0000_0100);
        issue(1'b0, 5'd4, 32'h0000_0100, 1'b0, 3'b000);
        expect_write("store");
        push(1'b0, 5'd0, 32'h0000_DEAD);
        issue(1'b1, 5'd0, 32'h0000_DEAD, 1'b0, 3'b000);
        expect_write("x0");

        // Load response while EMPTY is ignored.
        @(negedge clk);
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h1111_1111;
        @(negedge clk);
        bus.dmem_rvalid = 1'b0;
        check("stray_retire",  64'(bus.retire), 64'd0);
        check("stray_instret", bus.instret,     exp_cnt);

        // Bypass of a same-cycle write to the register being read.
`ifdef RV32I_WB_BYPASS_EN
        exp_fwd1 = 32'h0000_00A5;
`else
        exp_fwd1 = 32'h0000_0000;
`endif
        push(1'b1, 5'd7, 32'h0000_00A5);
        issue(1'b1, 5'd7, 32'h0000_00A5, 1'b0, 3'b000);
        check("fwd1", 64'(bus.fwd1_data), 64'(exp_fwd1));
        check("fwd2", 64'(bus.fwd2_data), 64'h55);
        expect_write("byp");

        // Reset in the middle of a load wait drops the load.
        issue(1'b1, 5'd6, 32'h0000_7000, 1'b1, 3'b010);
        check("rstld_pend", 64'(bus.pend_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rstld_pend0",  64'(bus.pend_valid), 64'd0);
        check("rstld_cnt0",   bus.instret,         64'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = '0;
        @(negedge clk);
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h2222_2222;
        @(negedge clk);
        bus.dmem_rvalid = 1'b0;
        check("rstld_retire", 64'(bus.retire),   64'd0);
        check("rstld_we",     64'(bus.RegWE),    64'd0);
        check("rstld_ready",  64'(bus.ex_ready), 64'd1);
        check("rstld_cnt",    bus.instret,       exp_cnt);
        check("sb_drained",   64'(sb.size()),    64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
